// File: rtl/decoder_3x8_pkg.sv
// decoder_3x8_pkg: shared widths and the active-high one-hot helper
package decoder_3x8_pkg;
  localparam int SEL_W = 3;
  localparam int OUT_W = 8;
  function automatic logic [OUT_W-1:0] onehot_of(input logic [SEL_W-1:0] sel);
    return OUT_W'(1) << sel;
  endfunction
endpackage

// File: rtl/decoder_3x8_core.sv
// decoder_3x8_core: combinational map of select index to active-high one-hot
module decoder_3x8_core
  import decoder_3x8_pkg::*;
(
  input  logic [SEL_W-1:0] I,
  output logic [OUT_W-1:0] onehot
);
  assign onehot = onehot_of(I);
endmodule

// File: rtl/decoder_3x8.sv
// decoder_3x8: registered 3-to-8 decoder with polarity option; DECODER_3X8_ONEHOT_CHK_EN adds sticky one-hot checker output err
module decoder_3x8
  import decoder_3x8_pkg::*;
#(
  parameter bit OUT_ACTIVE_LOW = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [SEL_W-1:0] I,
  output logic [OUT_W-1:0] out,
  output logic             valid
`ifdef DECODER_3X8_ONEHOT_CHK_EN
  ,
  output logic             err
`endif
);
  localparam logic [OUT_W-1:0] INACTIVE = {OUT_W{OUT_ACTIVE_LOW}};
  logic [OUT_W-1:0] hot;
  decoder_3x8_core u_core (.I(I), .onehot(hot));
  // capture decode (polarity applied) or fall back to the inactive pattern
  always_ff @(posedge clk) begin
    if (rst) begin
      out   <= INACTIVE;
      valid <= 1'b0;
    end else begin
      out   <= en ? hot ^ INACTIVE : INACTIVE;
      valid <= en;
    end
  end
`ifdef DECODER_3X8_ONEHOT_CHK_EN
  logic [OUT_W-1:0] norm;
  logic             bad;
  assign norm = out ^ INACTIVE;
  assign bad  = valid && (norm == '0 || (norm & (norm - OUT_W'(1))) != '0);
  // latch any integrity violation until reset
  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else if (bad) err <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_decoder_3x8.sv
// tb_decoder_3x8: directed and random checks of both polarities against a behavioural model
module tb_decoder_3x8;
  import decoder_3x8_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic [2:0] I = 3'd0;
  logic [7:0] out_h, out_l;
  logic valid_h, valid_l;
  int checks = 0;
  int failures = 0;
`ifdef DECODER_3X8_ONEHOT_CHK_EN
  logic err_h, err_l;
  logic err_exp_h = 1'b0;
`endif
  decoder_3x8 #(.OUT_ACTIVE_LOW(1'b0)) d0 (
    .clk(clk), .rst(rst), .en(en), .I(I), .out(out_h), .valid(valid_h)
`ifdef DECODER_3X8_ONEHOT_CHK_EN
    , .err(err_h)
`endif
  );
  decoder_3x8 #(.OUT_ACTIVE_LOW(1'b1)) d1 (
    .clk(clk), .rst(rst), .en(en), .I(I), .out(out_l), .valid(valid_l)
`ifdef DECODER_3X8_ONEHOT_CHK_EN
    , .err(err_l)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step(input logic r, input logic e, input int i);
    logic [7:0] exp_hi;
    rst = r;
    en = e;
    I = 3'(i);
    @(posedge clk);
    #1;
    exp_hi = (!r && e) ? 8'(2 ** i) : 8'h00;
    chk("out_h", out_h, exp_hi);
    chk("valid_h", {7'd0, valid_h}, {7'd0, !r && e});
    chk("out_l", out_l, (!r && e) ? ~exp_hi : 8'hFF);
    chk("valid_l", {7'd0, valid_l}, {7'd0, !r && e});
`ifdef DECODER_3X8_ONEHOT_CHK_EN
    if (r) err_exp_h = 1'b0;
    chk("err_h", {7'd0, err_h}, {7'd0, err_exp_h});
    chk("err_l", {7'd0, err_l}, 8'd0);
`endif
  endtask
  initial begin
    step(1, 1, 5);
    step(1, 1, 5);
    for (int i = 0; i < 8; i++) step(0, 1, i);
    step(0, 0, 3);
    step(0, 1, 3);
    step(0, 1, 6);
    step(0, 0, 6);
    step(0, 1, 7);
    step(1, 1, 2);
    step(0, 1, 2);
    begin
      logic [7:0] held;
      held = out_h;
      I = 3'd0;
      en = 1'b0;
      #3;
      chk("between_edges", out_h, held);
    end
    for (int n = 0; n < 200; n++)
      step($urandom_range(15) == 0, $urandom_range(3) != 0, int'($urandom_range(7)));
`ifdef DECODER_3X8_ONEHOT_CHK_EN
    step(0, 1, 1);
    force d0.out = 8'h03;
    @(posedge clk);
    #1;
    release d0.out;
    err_exp_h = 1'b1;
    chk("err_set", {7'd0, err_h}, 8'd1);
    step(0, 1, 4);
    step(0, 0, 4);
    step(1, 1, 0);
    step(0, 1, 5);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
